au_cmp_iter: RTL and testbench

Iterative magnitude/equality comparator for two WIDTH-bit operands that examines CHUNK bits per cycle from MSB to LSB. It terminates early at the first differing chunk and supports unsigned or two's-complement interpretation per transaction. Both sides use a valid/ready handshake. It is the area-reduced, multi-mode successor to the single-cycle equality comparator and is used in arithmetic datapaths where wide compares must not set the critical path.

---
 rtl/au_cmp_iter_if.sv | 27 ++
 rtl/au_cmp_iter.sv | 118 +++++++++++
 tb/tb_au_cmp_iter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/au_cmp_iter_if.sv
// Handshake and operand/result bundle for the iterative comparator.
// master drives operands and out_ready; slave is the comparator itself.
interface au_cmp_iter_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             tc;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             lt;
    logic             gt;
    logic             busy;

    modport master (
        output in_valid, a, b, tc, out_ready,
        input  in_ready, out_valid, eq, lt, gt, busy
    );

    modport slave (
        input  in_valid, a, b, tc, out_ready,
        output in_ready, out_valid, eq, lt, gt, busy
    );
endinterface

// File: rtl/au_cmp_iter.sv
// Iterative comparator: walks CHUNK-bit slices from MSB to LSB and stops at
// the first differing slice; tc selects two's-complement ordering per compare.
module au_cmp_iter #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    au_cmp_iter_if.slave cmp_bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW     = NCHUNK * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH) begin : g_param_err
        $fatal(1, "au_cmp_iter: illegal WIDTH=%0d / CHUNK=%0d", WIDTH, CHUNK);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_b;
    logic [IW-1:0]    r_idx;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_sign_mask;
    logic [WIDTH-1:0] w_a_cap;
    logic [WIDTH-1:0] w_b_cap;
    logic [CHUNK-1:0] w_a_chunk [NCHUNK];
    logic [CHUNK-1:0] w_b_chunk [NCHUNK];
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_differ;
    logic             w_last;

    // Flipping both MSBs maps signed order onto unsigned order.
    assign w_sign_mask = WIDTH'(cmp_bus.tc) << (WIDTH - 1);
    assign w_a_cap     = cmp_bus.a ^ w_sign_mask;
    assign w_b_cap     = cmp_bus.b ^ w_sign_mask;

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        assign w_a_chunk[gi] = r_a[gi*CHUNK +: CHUNK];
        assign w_b_chunk[gi] = r_b[gi*CHUNK +: CHUNK];
    end

    assign w_ca     = w_a_chunk[r_idx];
    assign w_cb     = w_b_chunk[r_idx];
    assign w_differ = (w_ca != w_cb);
    assign w_last   = (r_idx == '0);

    assign w_in_ready = (r_state == S_IDLE) || (r_state == S_DONE && cmp_bus.out_ready);
    assign w_accept   = cmp_bus.in_valid && w_in_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_differ || w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                // A new compare may start on the same edge as the result handoff.
                if (cmp_bus.out_ready) w_state_next = w_accept ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= PW'(w_a_cap);
                r_b   <= PW'(w_b_cap);
                r_idx <= IW'(NCHUNK - 1);
            end else if (r_state == S_RUN) begin
                if (w_differ) begin
                    r_eq <= 1'b0;
                    r_lt <= (w_ca < w_cb);
                    r_gt <= (w_ca > w_cb);
                end else if (w_last) begin
                    r_eq <= 1'b1;
                    r_lt <= 1'b0;
                    r_gt <= 1'b0;
                end else begin
                    r_idx <= r_idx - IW'(1);
                end
            end
        end
    end

    assign cmp_bus.in_ready  = w_in_ready;
    assign cmp_bus.out_valid = (r_state == S_DONE);
    assign cmp_bus.busy      = (r_state == S_RUN);
    assign cmp_bus.eq        = r_eq;
    assign cmp_bus.lt        = r_lt;
    assign cmp_bus.gt        = r_gt;
endmodule

// File: tb/tb_au_cmp_iter.sv
// Scoreboard bench for au_cmp_iter: one instance at WIDTH=8/CHUNK=2 and one at
// WIDTH=7/CHUNK=3 (padded top chunk), sharing clock and reset.
module tb_au_cmp_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    au_cmp_iter_if #(.WIDTH(8)) if8 ();
    au_cmp_iter_if #(.WIDTH(7)) if7 ();

    au_cmp_iter #(.WIDTH(8), .CHUNK(2)) u_dut8 (.clk(clk), .rst_n(rst_n), .cmp_bus(if8.slave));
    au_cmp_iter #(.WIDTH(7), .CHUNK(3)) u_dut7 (.clk(clk), .rst_n(rst_n), .cmp_bus(if7.slave));

    localparam logic [2:0] R_EQ = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    typedef struct {
        logic [2:0] flags;
        int         k;
        int         due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic seen [2];
    int   bcnt [2];
    exp_t held [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference ordering from integer values, independent of any chunking.
    function automatic logic [2:0] ref_flags(input int w, input logic [7:0] a, input logic [7:0] b,
                                             input logic tc);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (tc && a[w-1]) sa = sa - (1 << w);
        if (tc && b[w-1]) sb = sb - (1 << w);
        return {sa == sb, sa < sb, sa > sb};
    endfunction

    function automatic int ref_k(input int w, input int c, input logic [7:0] a, input logic [7:0] b);
        int nch;
        int d;
        nch = (w + c - 1) / c;
        d   = int'(a ^ b);
        for (int i = nch - 1; i >= 0; i--) begin
            if (((d >> (i * c)) & ((1 << c) - 1)) != 0) return nch - i;
        end
        return nch;
    endfunction

    task automatic mon(input int sel);
        logic       ov;
        logic       bz;
        logic       orr;
        logic [2:0] fl;
        logic       empty;
        exp_t       e;
        if (sel == 0) begin
            ov = if8.out_valid; bz = if8.busy; orr = if8.out_ready; fl = {if8.eq, if8.lt, if8.gt};
        end else begin
            ov = if7.out_valid; bz = if7.busy; orr = if7.out_ready; fl = {if7.eq, if7.lt, if7.gt};
        end
        if (bz) bcnt[sel]++;
        if (ov && !seen[sel]) begin
            empty = (sel == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                check("unexpected_out", 32'(ov), 32'd0);
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                $display("dut%0d result eq=%b lt=%b gt=%b cycle=%0d busy_cycles=%0d",
                         sel, fl[2], fl[1], fl[0], cyc, bcnt[sel]);
                check("flags", 32'(fl), 32'(e.flags));
                check("onehot", 32'(fl[2]) + 32'(fl[1]) + 32'(fl[0]), 32'd1);
                check("latency", 32'(cyc), 32'(e.due));
                check("busy_cycles", 32'(bcnt[sel]), 32'(e.k));
                held[sel] = e;
            end
            bcnt[sel] = 0;
            seen[sel] = 1'b1;
        end else if (ov && seen[sel]) begin
            check("held_flags", 32'(fl), 32'(held[sel].flags));
        end
        if (ov && orr) seen[sel] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 2; i++) begin
                seen[i] = 1'b0;
                bcnt[i] = 0;
            end
        end else begin
            mon(0);
            mon(1);
        end
    end

    task automatic drive(input int sel, input logic [7:0] a, input logic [7:0] b, input logic tc,
                         input logic [2:0] flags, input int k);
        int   n;
        logic rdy;
        exp_t e;
        if (sel == 0) begin
            if8.in_valid = 1'b1; if8.a = a; if8.b = b; if8.tc = tc;
        end else begin
            if7.in_valid = 1'b1; if7.a = a[6:0]; if7.b = b[6:0]; if7.tc = tc;
        end
        n = 0;
        do begin
            @(negedge clk);
            rdy = (sel == 0) ? if8.in_ready : if7.in_ready;
            n++;
        end while (!rdy && n < 60);
        if (!rdy) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.flags = flags;
            e.k     = k;
            e.due   = cyc + 1 + k;
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sel == 0) if8.in_valid = 1'b0;
        else          if7.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || if8.busy || if7.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", 32'(q0.size() + q1.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input int sel);
        if (sel == 0) begin
            check("rst_out_valid", 32'(if8.out_valid), 32'd0);
            check("rst_busy", 32'(if8.busy), 32'd0);
            check("rst_flags", 32'({if8.eq, if8.lt, if8.gt}), 32'd0);
            check("rst_in_ready", 32'(if8.in_ready), 32'd1);
        end else begin
            check("rst_out_valid7", 32'(if7.out_valid), 32'd0);
            check("rst_busy7", 32'(if7.busy), 32'd0);
            check("rst_flags7", 32'({if7.eq, if7.lt, if7.gt}), 32'd0);
            check("rst_in_ready7", 32'(if7.in_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rtc;
        int         nw;

        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.tc = 1'b0; if8.out_ready = 1'b1;
        if7.in_valid = 1'b0; if7.a = '0; if7.b = '0; if7.tc = 1'b0; if7.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_idle_reset(0);
        check_idle_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed compares at WIDTH=8, CHUNK=2.
        drive(0, 8'h5A, 8'h5A, 1'b0, R_EQ, 4);
        drive(0, 8'h80, 8'h7F, 1'b0, R_GT, 1);
        drive(0, 8'h80, 8'h7F, 1'b1, R_LT, 1);
        drive(0, 8'h12, 8'h13, 1'b0, R_LT, 4);
        drive(0, 8'hFF, 8'hFE, 1'b1, R_GT, 4);
        drain();

        // Backpressure in DONE, then an accept on the handoff edge.
        if8.out_ready = 1'b0;
        drive(0, 8'h12, 8'h13, 1'b0, R_LT, 4);
        nw = 0;
        do begin
            @(negedge clk);
            nw++;
        end while (!if8.out_valid && nw < 20);
        check("bp_reach_done", 32'(if8.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.tc = 1'($urandom);
            if8.in_valid = ~if8.in_valid;
            @(negedge clk);
            check("bp_in_ready", 32'(if8.in_ready), 32'd0);
            check("bp_out_valid", 32'(if8.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        if8.out_ready = 1'b1;
        drive(0, 8'h01, 8'h02, 1'b0, R_LT, 4);
        drain();

        // Reset two cycles into an equal compare: nothing may come out.
        drive(0, 8'h5A, 8'h5A, 1'b0, R_EQ, 4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_reset(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(if8.in_ready), 32'd1);
        repeat (8) @(negedge clk);
        check("post_rst_no_out", 32'(if8.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Random back-to-back compares at WIDTH=8, CHUNK=2.
        for (int i = 0; i < 16; i++) begin
            ra  = 8'($urandom);
            rb  = (i % 4 == 0) ? ra : 8'($urandom);
            if (i % 4 == 1) rb = ra ^ 8'h01;
            rtc = 1'($urandom);
            drive(0, ra, rb, rtc, ref_flags(8, ra, rb, rtc), ref_k(8, 2, ra, rb));
        end
        drain();

        // WIDTH=7, CHUNK=3 with a padded top chunk.
        drive(1, 8'h40, 8'h3F, 1'b0, R_GT, 1);
        drive(1, 8'h40, 8'h3F, 1'b1, R_LT, 1);
        drive(1, 8'h55, 8'h55, 1'b0, R_EQ, 3);
        drive(1, 8'h7F, 8'h00, 1'b1, R_LT, 1);
        for (int i = 0; i < 12; i++) begin
            ra  = 8'($urandom) & 8'h7F;
            rb  = (i % 3 == 0) ? (ra ^ 8'h02) : (8'($urandom) & 8'h7F);
            rtc = 1'($urandom);
            drive(1, ra, rb, rtc, ref_flags(7, ra, rb, rtc), ref_k(7, 3, ra, rb));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
